// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: debounced two-key operand-entry sequencer for a switch-driven adder.
module calc_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             KEY_ENTER_N,
  input  logic             KEY_CLEAR_N,
  input  logic [WIDTH-1:0] SW,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] LED,
  output logic             LED_COUT,
  output logic [1:0]       state,
  output logic [7:0]       op_count
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {WAIT_A = 2'b00, WAIT_B = 2'b01, CALC = 2'b10, SHOW = 2'b11} state_t;
  // Bit 0 is enter, bit 1 is clear; both keys share one conditioning path.
  logic [1:0] keys, s1_q, s2_q, acc_q, prev_q, pulse_q;
  logic [CW-1:0] cnt_q [2];
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic cout_q, cout_d;
  logic [7:0] ops_q, ops_d;
  assign keys = {KEY_CLEAR_N, KEY_ENTER_N};
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      s1_q    <= '1;
      s2_q    <= '1;
      acc_q   <= '1;
      prev_q  <= '1;
      pulse_q <= '0;
      for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
    end else begin
      s1_q    <= keys;
      s2_q    <= s1_q;
      prev_q  <= acc_q;
      pulse_q <= prev_q & ~acc_q;
      for (int k = 0; k < 2; k++) begin
        if (s2_q[k] == acc_q[k]) cnt_q[k] <= '0;
        else if (cnt_q[k] == CMAX) begin
          acc_q[k] <= s2_q[k];
          cnt_q[k] <= '0;
        end else cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ops_q   <= ops_d;
    end
  end
  // Clear overrides everything, including the CALC commit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ops_d   = ops_q;
    if (pulse_q[1]) begin
      state_d = WAIT_A;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      cout_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_A: if (pulse_q[0]) begin
          a_d     = SW;
          state_d = WAIT_B;
        end
        WAIT_B: if (pulse_q[0]) begin
          b_d     = SW;
          state_d = CALC;
        end
        CALC: begin
          res_d   = add_sum;
          cout_d  = add_cout;
          ops_d   = ops_q + 8'd1;
          state_d = SHOW;
        end
        default: if (pulse_q[0]) begin
          a_d     = SW;
          b_d     = '0;
          state_d = WAIT_B;
        end
      endcase
    end
  end
  assign op_a     = a_q;
  assign op_b     = b_q;
  assign LED      = (state_q == WAIT_B) ? a_q : res_q;
  assign LED_COUT = cout_q;
  assign state    = state_q;
  assign op_count = ops_q;
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed table plus timed sequences for calc_seq_ctrl with a 4-cycle debounce.
module tb_calc_seq_ctrl;
  logic CLOCK_50 = 1'b0;
  logic RESET_N = 1'b0;
  logic KEY_ENTER_N = 1'b1;
  logic KEY_CLEAR_N = 1'b1;
  logic [3:0] SW = 4'h0;
  logic [3:0] add_sum, op_a, op_b, LED;
  logic add_cout, LED_COUT;
  logic [1:0] state;
  logic [7:0] op_count;
  int vecs = 0;
  int errs = 0;
  typedef struct {
    logic       en;
    logic       cl;
    logic [3:0] sw;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] led;
    logic       cout;
    logic [1:0] st;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl [13];
  calc_seq_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY_ENTER_N(KEY_ENTER_N), .KEY_CLEAR_N(KEY_CLEAR_N),
    .SW(SW), .add_sum(add_sum), .add_cout(add_cout), .op_a(op_a), .op_b(op_b), .LED(LED),
    .LED_COUT(LED_COUT), .state(state), .op_count(op_count)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  assign {add_cout, add_sum} = {1'b0, op_a} + {1'b0, op_b};
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
    end
  endtask
  task automatic press(input logic en, input logic cl, input logic [3:0] sw, input int low);
    SW = sw;
    KEY_ENTER_N = ~en;
    KEY_CLEAR_N = ~cl;
    tick(low);
    KEY_ENTER_N = 1'b1;
    KEY_CLEAR_N = 1'b1;
    tick(8);
  endtask
  task automatic chk_all(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [3:0] led,
                         input logic cout, input logic [1:0] st, input logic [7:0] cnt);
    chk({tag, ".op_a"}, 8'(op_a), 8'(a));
    chk({tag, ".op_b"}, 8'(op_b), 8'(b));
    chk({tag, ".led"}, 8'(LED), 8'(led));
    chk({tag, ".cout"}, 8'(LED_COUT), 8'(cout));
    chk({tag, ".state"}, 8'(state), 8'(st));
    chk({tag, ".count"}, op_count, cnt);
  endtask
  initial begin
    logic saw_b;
    tbl[0]  = '{1'b1, 1'b0, 4'h3, 4'h3, 4'h0, 4'h3, 1'b0, 2'd1, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 4'h5, 4'h3, 4'h5, 4'h8, 1'b0, 2'd3, 8'd1};
    tbl[2]  = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 4'hF, 1'b0, 2'd1, 8'd1};
    tbl[3]  = '{1'b1, 1'b0, 4'h1, 4'hF, 4'h1, 4'h0, 1'b1, 2'd3, 8'd2};
    tbl[4]  = '{1'b1, 1'b0, 4'h6, 4'h6, 4'h0, 4'h6, 1'b1, 2'd1, 8'd2};
    tbl[5]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'd2};
    tbl[6]  = '{1'b1, 1'b0, 4'h9, 4'h9, 4'h0, 4'h9, 1'b0, 2'd1, 8'd2};
    tbl[7]  = '{1'b1, 1'b0, 4'h9, 4'h9, 4'h9, 4'h2, 1'b1, 2'd3, 8'd3};
    tbl[8]  = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'd3};
    tbl[9]  = '{1'b1, 1'b0, 4'h7, 4'h7, 4'h0, 4'h7, 1'b0, 2'd1, 8'd3};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 4'h7, 4'h0, 4'h7, 1'b0, 2'd3, 8'd4};
    tbl[11] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'd4};
    tbl[12] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'd4};
    tick(3);
    chk_all("reset", 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'd0);
    RESET_N = 1'b1;
    tick(2);
    for (int i = 0; i < 13; i++) begin
      press(tbl[i].en, tbl[i].cl, tbl[i].sw, 7);
      chk_all($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].led, tbl[i].cout, tbl[i].st, tbl[i].cnt);
    end
    SW = 4'hA;
    KEY_ENTER_N = 1'b0; tick(3);
    KEY_ENTER_N = 1'b1; tick(2);
    KEY_ENTER_N = 1'b0; tick(3);
    KEY_ENTER_N = 1'b1; tick(12);
    chk("bounce.state", 8'(state), 8'd0);
    chk("bounce.op_a", 8'(op_a), 8'd0);
    SW = 4'h4;
    KEY_ENTER_N = 1'b0;
    tick(7);
    chk("clean.edge6.state", 8'(state), 8'd0);
    KEY_ENTER_N = 1'b1;
    tick(1);
    chk("clean.edge7.state", 8'(state), 8'd1);
    chk("clean.edge7.op_a", 8'(op_a), 8'h4);
    tick(8);
    SW = 4'h1;
    KEY_ENTER_N = 1'b0;
    tick(7);
    chk("bcap.edge6.state", 8'(state), 8'd1);
    chk("bcap.edge6.led", 8'(LED), 8'h4);
    KEY_ENTER_N = 1'b1;
    tick(1);
    chk("bcap.calc.state", 8'(state), 8'd2);
    chk("bcap.calc.op_b", 8'(op_b), 8'h1);
    tick(1);
    chk_all("bcap.show", 4'h4, 4'h1, 4'h5, 1'b0, 2'd3, 8'd5);
    tick(8);
    press(1'b1, 1'b0, 4'h4, 7);
    chk("simul.pre.state", 8'(state), 8'd1);
    saw_b = 1'b0;
    SW = 4'hC;
    KEY_ENTER_N = 1'b0;
    KEY_CLEAR_N = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i == 10) begin
        KEY_ENTER_N = 1'b1;
        KEY_CLEAR_N = 1'b1;
      end
      tick(1);
      if (i >= 7 && state == 2'd1) saw_b = 1'b1;
    end
    chk("simul.saw_wait_b", 8'(saw_b), 8'd0);
    chk_all("simul", 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'd5);
    press(1'b1, 1'b0, 4'h6, 7);
    chk("rst.pre.op_a", 8'(op_a), 8'h6);
    RESET_N = 1'b0;
    tick(1);
    chk_all("rst.midb", 4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 8'd0);
    SW = 4'h2;
    KEY_ENTER_N = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(7);
    chk("held.edge6.state", 8'(state), 8'd0);
    tick(1);
    chk("held.edge7.state", 8'(state), 8'd1);
    chk("held.edge7.op_a", 8'(op_a), 8'h2);
    KEY_ENTER_N = 1'b1;
    tick(8);
    RESET_N = 1'b0;
    tick(1);
    RESET_N = 1'b1;
    tick(1);
    for (int i = 0; i < 256; i++) begin
      press(1'b1, 1'b0, 4'(i), 7);
      press(1'b1, 1'b0, 4'(i >> 4), 7);
      if (i == 254) chk("wrap.count255", op_count, 8'd255);
    end
    chk_all("wrap", 4'hF, 4'hF, 4'hE, 1'b1, 2'd3, 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
